// File: rtl/axis_frame_arb_if.sv
// AXI-Stream bundle shared by the arbiter's two source ports and its master port.
interface axis_frame_arb_if #(
    parameter int DATA_W = 32
);
    logic                  tvalid;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic                  tready;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin 2:1 AXI-Stream arbiter with a registered output stage and
// frame-length watchdog. Optional per-source frame counters under AXIS_ARB_STATS_EN.
module axis_frame_arb #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    axis_frame_arb_if.slave          s0_axis,
    axis_frame_arb_if.slave          s1_axis,
    axis_frame_arb_if.master         m_axis,
    output logic [1:0]               grant,
    output logic                     trunc,
`ifdef AXIS_ARB_STATS_EN
    output logic [15:0]              frames0,
    output logic [15:0]              frames1,
`endif
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    localparam bit                WD_EN   = (MAX_WORDS != 0);
    localparam logic [CNT_W-1:0]  CNT_LIM = WD_EN ? CNT_W'(MAX_WORDS - 1) : '0;

    state_e              state_q;
    logic [1:0]          grant_q;
    logic                last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;

    logic                out_free;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                acc;
    logic                force_last;
    logic                eff_last;

    // Handshake: a beat moves on a rising edge where tvalid & tready are both high; a source
    // holds tvalid/tdata/tlast until accepted, and the output holds its beat until accepted.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        case (state_q)
            ST_G0: begin
                sel_valid = s0_axis.tvalid;
                sel_last  = s0_axis.tlast;
                sel_data  = s0_axis.tdata;
            end
            ST_G1: begin
                sel_valid = s1_axis.tvalid;
                sel_last  = s1_axis.tlast;
                sel_data  = s1_axis.tdata;
            end
            default: ;
        endcase
    end

    assign out_free       = !m_valid_q || m_axis.tready;
    assign s0_axis.tready = !rst && (state_q == ST_G0) && out_free;
    assign s1_axis.tready = !rst && (state_q == ST_G1) && out_free;
    assign acc            = !rst && (state_q != ST_IDLE) && sel_valid && out_free;

    assign force_last = WD_EN && (cnt_q == CNT_LIM) && !sel_last;
    assign eff_last   = sel_last || force_last;
    assign trunc      = acc && force_last;

    // Saturation only matters with the watchdog off; otherwise cnt stops at MAX_WORDS-1.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            if (acc) begin
                m_valid_q <= 1'b1;
                m_data_q  <= sel_data;
                m_last_q  <= eff_last;
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (s0_axis.tvalid && (!s1_axis.tvalid || last_grant_q)) begin
                        state_q <= ST_G0;
                        grant_q <= 2'b01;
                    end else if (s1_axis.tvalid) begin
                        state_q <= ST_G1;
                        grant_q <= 2'b10;
                    end
                end
                ST_G0, ST_G1: begin
                    if (acc) begin
                        if (eff_last) begin
                            state_q      <= ST_IDLE;
                            grant_q      <= 2'b00;
                            last_grant_q <= (state_q == ST_G1);
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

`ifdef AXIS_ARB_STATS_EN
    logic [15:0] frames0_q;
    logic [15:0] frames1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames0_q <= '0;
            frames1_q <= '0;
        end else if (acc && eff_last) begin
            if (state_q == ST_G0) frames0_q <= frames0_q + 16'd1;
            if (state_q == ST_G1) frames1_q <= frames1_q + 16'd1;
        end
    end

    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
`endif

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tstrb  = '1;
    assign grant         = grant_q;
    assign dbg_state_o   = state_q;

endmodule
